// File: rtl/dmem_if.sv
// Load/store request and response channels between the core MEM stage (master)
// and the data-memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_store_type;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Both channels use the same valid/ready rule. A transfer happens on a rising
    // edge where valid & ready are both high. Once valid is raised, it stays high
    // and the payload stays stable until that transfer occurs.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_store_type, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_store_type, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte-lane stores and configurable wait states.
// Optional access-fault reporting is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset_n,
    dmem_if.slave      bus,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_type;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_write;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [1:0]       w_type;
    logic [31:0]      w_off;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_lanes;
    logic             w_err;
    logic             w_block;
    logic             w_mem_we;
    logic [31:0]      w_rdata;

    assign w_accept     = bus.req_valid && (r_state == ST_IDLE);
    assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    // With zero wait states the access happens on the accept edge, before the
    // capture registers are loaded, so decode from the bus directly in IDLE.
    assign w_write = (r_state == ST_IDLE) ? bus.req_write      : r_write;
    assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr       : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata      : r_wdata;
    assign w_type  = (r_state == ST_IDLE) ? bus.req_store_type : r_type;

    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_off} < SPAN;
    assign w_idx      = w_off[IDX_W+1:2];

    always_comb begin
        w_be    = 4'b0000;
        w_lanes = 32'd0;
        case (w_type)
            2'd0: begin
                w_be    = 4'b0001 << w_off[1:0];
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'd1: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            2'd2: begin
                w_be    = 4'b1111;
                w_lanes = w_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_lanes = 32'd0;
            end
        endcase
    end

`ifdef DMEM_ERR_CHECK_EN
    logic w_bad_shape;
    assign w_bad_shape = (w_type == 2'd3) ||
                         ((w_type == 2'd1) && w_off[0]) ||
                         ((w_type == 2'd2) && (w_off[1:0] != 2'b00));
    assign w_err = !w_in_range || w_bad_shape;
`else
    assign w_err = 1'b0;
`endif

    assign w_block  = !w_in_range || w_err;
    assign w_mem_we = reset_n && w_enter_resp && w_write && !w_block;
    assign w_rdata  = (w_write || w_block) ? 32'd0 : r_mem[w_idx];

    // Backing array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_type      <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_type  <= bus.req_store_type;
                        if (WAIT_STATES == 0) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign o_dbg_state   = r_state;

endmodule
